// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - limb-serial multi-precision add/sub sequencer around an external 32-bit adder
module multiword_add_seq #(
  parameter int WORDS = 4,
  parameter int CW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic          in_sub,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_cin,
  input  logic [31:0]   add_sum,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          out_last,
  output logic          out_carry
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy_q, cy_d;
  logic          sub_q, sub_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic          out_last_q, out_last_d;
  logic          out_carry_q, out_carry_d;

  logic first_limb, last_limb, op, accept;

  always_comb begin
    first_limb = (cnt_q == '0);
    last_limb  = (cnt_q == LAST_IDX);
    // Limb 0 takes the operation straight from the input; later limbs use the latched flag.
    op         = first_limb ? in_sub : sub_q;

    add_a      = in_a;
    add_b      = in_b ^ {32{op}};
    add_cin    = first_limb ? in_sub : cy_q;

    in_ready   = !out_valid_q || out_ready;
    accept     = in_valid && in_ready;

    cnt_d       = cnt_q;
    cy_d        = cy_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;

    if (accept) begin
      out_sum_d   = add_sum;
      out_valid_d = 1'b1;
      out_last_d  = last_limb;
      cy_d        = add_cout;
      out_carry_d = last_limb ? (add_cout ^ op) : 1'b0;
      cnt_d       = last_limb ? '0 : cnt_q + CW'(1);
      if (first_limb) begin
        sub_d = in_sub;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      cy_q        <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cy_q        <= cy_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;

endmodule
